// File: rtl/wbus_arbiter_pkg.sv
// Shared constants for the write-bus arbiter: FSM encodings, arb_status
// field positions and well-known master indices.
package wbus_arbiter_pkg;

    typedef enum logic [1:0] {
        WBA_IDLE  = 2'd0,
        WBA_GRANT = 2'd1,
        WBA_BLOCK = 2'd2,
        WBA_GAP   = 2'd3
    } wba_state_t;

    // arb_status = {timeout_cnt, 4'd0, last_owner, 5'd0, blk_active, state}
    localparam int WBA_ST_STATE_LSB = 0;
    localparam int WBA_ST_BLK_BIT   = 2;
    localparam int WBA_ST_OWNER_LSB = 8;
    localparam int WBA_ST_TCNT_LSB  = 16;

    localparam int WBA_RT  = 0;
    localparam int WBA_FW  = 1;
    localparam int WBA_ETH = 2;

endpackage

// File: rtl/wba_pick.sv
// Combinational winner selection: fixed priority (lowest index) or
// index 0 highest with the remaining masters served round-robin from ptr.
module wba_pick #(
    parameter int NUM_REQ   = 3,
    parameter int PRIO_MODE = 0,
    localparam int IW       = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IW-1:0]      win_idx,
    output logic               any_valid
);

    logic found;
    int   sel;
    int   cand;

    always_comb begin
        found = 1'b0;
        sel   = 0;
        cand  = 0;
        if (PRIO_MODE == 0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i]) begin
                    found = 1'b1;
                    sel   = i;
                end
            end
        end else if (req[0]) begin
            found = 1'b1;
            sel   = 0;
        end else begin
            // Walk masters 1..NUM_REQ-1 starting at ptr, wrapping back to 1.
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                cand = int'(ptr) + k;
                if (cand > NUM_REQ - 1) cand = cand - (NUM_REQ - 1);
                if (!found && cand < NUM_REQ && req[cand]) begin
                    found = 1'b1;
                    sel   = cand;
                end
            end
        end
        any_valid = found;
        win_idx   = IW'(sel);
        win_oh    = found ? (NUM_REQ'(1) << sel) : '0;
    end

endmodule

// File: rtl/wbus_arbiter.sv
// Request/grant arbiter for the shared register write bus, with block-write
// locking, a hold watchdog and fully registered bus outputs.
module wbus_arbiter
    import wbus_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int PRIO_MODE    = 0,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                    sysclk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      m_reg_wen,
    input  logic [NUM_REQ-1:0]      m_blk_wen,
    input  logic [NUM_REQ-1:0]      m_blk_wstart,
    input  logic [16*NUM_REQ-1:0]   m_waddr,
    input  logic [32*NUM_REQ-1:0]   m_wdata,
    output logic [NUM_REQ-1:0]      gnt,
    output logic                    reg_wen,
    output logic                    blk_wen,
    output logic                    blk_wstart,
    output logic [15:0]             reg_waddr,
    output logic [31:0]             reg_wdata,
    output logic [31:0]             arb_status,
    output logic                    timeout_evt
);

    localparam int IW = $clog2(NUM_REQ);

    // Handshake: a master holds req high for as long as it wants the bus; its
    // strobes are honoured only while its gnt bit is high, and dropping req
    // releases the bus after any strobe issued in that same cycle.
    wba_state_t           state;
    logic [IW-1:0]        owner;
    logic [IW-1:0]        rr_ptr;
    logic [15:0]          hold_cnt;
    logic [15:0]          timeout_cnt;
    logic [3:0]           last_owner;
    logic                 blk_active;

    logic [NUM_REQ-1:0]   win_oh;
    logic [IW-1:0]        win_idx;
    logic                 any_valid;

    logic                 own_req, own_wen, own_bwen, own_bst, hold_hit;
    logic [15:0]          own_addr;
    logic [31:0]          own_data;

    wba_pick #(
        .NUM_REQ   (NUM_REQ),
        .PRIO_MODE (PRIO_MODE)
    ) u_pick (
        .req       (req),
        .ptr       (rr_ptr),
        .win_oh    (win_oh),
        .win_idx   (win_idx),
        .any_valid (any_valid)
    );

    assign own_req  = req[owner];
    assign own_wen  = m_reg_wen[owner];
    assign own_bwen = m_blk_wen[owner];
    assign own_bst  = m_blk_wstart[owner];
    assign own_addr = m_waddr[{owner, 4'b0000} +: 16];
    assign own_data = m_wdata[{owner, 5'b00000} +: 32];
    assign hold_hit = (hold_cnt == 16'(HOLD_TIMEOUT - 1));

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state       <= WBA_IDLE;
            gnt         <= '0;
            owner       <= '0;
            rr_ptr      <= IW'(1);
            hold_cnt    <= '0;
            timeout_cnt <= '0;
            last_owner  <= '0;
            blk_active  <= 1'b0;
            timeout_evt <= 1'b0;
            reg_wen     <= 1'b0;
            blk_wen     <= 1'b0;
            blk_wstart  <= 1'b0;
            reg_waddr   <= '0;
            reg_wdata   <= '0;
        end else begin
            reg_wen     <= 1'b0;
            blk_wen     <= 1'b0;
            blk_wstart  <= 1'b0;
            timeout_evt <= 1'b0;
            case (state)
                WBA_IDLE: begin
                    if (any_valid) begin
                        gnt        <= win_oh;
                        owner      <= win_idx;
                        last_owner <= 4'(win_idx);
                        hold_cnt   <= '0;
                        state      <= WBA_GRANT;
                        if (PRIO_MODE == 1 && win_idx != '0)
                            rr_ptr <= (win_idx == IW'(NUM_REQ - 1)) ? IW'(1) : win_idx + IW'(1);
                    end
                end
                WBA_GRANT, WBA_BLOCK: begin
                    if (hold_hit) begin
                        // Revoke: the owner's strobes this cycle never reach the bus.
                        gnt         <= '0;
                        timeout_evt <= 1'b1;
                        blk_active  <= 1'b0;
                        state       <= WBA_GAP;
                        if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
                    end else begin
                        reg_wen    <= own_wen;
                        blk_wen    <= own_bwen;
                        blk_wstart <= own_bst;
                        if (own_wen || own_bwen || own_bst) begin
                            reg_waddr <= own_addr;
                            reg_wdata <= own_data;
                        end
                        hold_cnt <= hold_cnt + 16'd1;
                        if (!own_req) begin
                            gnt        <= '0;
                            blk_active <= 1'b0;
                            state      <= WBA_GAP;
                        end else if (state == WBA_GRANT && own_bst) begin
                            blk_active <= 1'b1;
                            state      <= WBA_BLOCK;
                        end
                    end
                end
                WBA_GAP: state <= WBA_IDLE;
            endcase
        end
    end

    always_comb begin
        arb_status = '0;
        arb_status[WBA_ST_STATE_LSB +: 2]  = state;
        arb_status[WBA_ST_BLK_BIT]         = blk_active;
        arb_status[WBA_ST_OWNER_LSB +: 4]  = last_owner;
        arb_status[WBA_ST_TCNT_LSB +: 16]  = timeout_cnt;
    end

endmodule

// File: doc/wbus_arbiter.md
Name: wbus_arbiter

Overview:
- Arbitrates the shared register write bus (reg_wen, blk_wen, blk_wstart, reg_waddr, reg_wdata) between several masters, e.g. the real-time block writer, Firewire and the Ethernet host path.
- Replaces the combinational select-on-enable mux with a request/grant handshake. A block write (blk_wstart .. final blk_wen) is never interleaved with another master's writes.
- A watchdog revokes a grant held by a stuck master.
- Sits between the write-bus masters and all write-bus slaves (HubReg, M25P16, BoardRegs, motor/encoder channels).

Parameters:
- NUM_REQ, 3, number of masters (2..8); index 0 is the real-time block writer.
- PRIO_MODE, 0, 0 = fixed priority (lowest index wins); 1 = index 0 fixed highest, remaining masters round-robin.
- HOLD_TIMEOUT, 1024, max consecutive sysclk cycles one grant may be held; must be >= 2 and < 65536.

Ports:
- sysclk  in  1  global clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-master request, level
- m_reg_wen  in  NUM_REQ  per-master register write strobe
- m_blk_wen  in  NUM_REQ  per-master block write strobe
- m_blk_wstart  in  NUM_REQ  per-master block start strobe
- m_waddr  in  16*NUM_REQ  packed write addresses, master i at [16i+15:16i]
- m_wdata  in  32*NUM_REQ  packed write data, master i at [32i+31:32i]
- gnt  out  NUM_REQ  one-hot grant
- reg_wen  out  1  arbitrated register write strobe
- blk_wen  out  1  arbitrated block write strobe
- blk_wstart  out  1  arbitrated block start strobe
- reg_waddr  out  16  arbitrated write address
- reg_wdata  out  32  arbitrated write data
- arb_status  out  32  {timeout_cnt[15:0], 4'd0, last_owner[3:0], 5'd0, blk_active, state[1:0]}
- timeout_evt  out  1  one-cycle pulse when a grant is revoked

Behaviour:
- Reset values:
  - gnt = 0; all strobes = 0; reg_waddr = 0; reg_wdata = 0.
  - state = IDLE; last_owner = 0; timeout_cnt = 0; blk_active = 0; timeout_evt = 0; round-robin pointer = 1.
- Reset mid-transaction drops the grant and strobes the next cycle, with no trailing write.
- States (encoding): IDLE=0, GRANT=1, BLOCK=2, GAP=3.
- IDLE:
  - If any req is set, pick the winner and register gnt[w]=1 on the next edge, then go to GRANT.
  - Request-to-grant latency is 1 cycle.
  - PRIO_MODE 0: lowest index wins.
  - PRIO_MODE 1: index 0 wins if requesting; otherwise search starts at the pointer. After a grant to w != 0, the pointer becomes w+1, wrapping from NUM_REQ-1 to 1.
- GRANT:
  - Master strobes are forwarded only when gnt[i]=1. Non-owner strobes are ignored and dropped.
  - m_blk_wstart from the owner sets blk_active and moves to BLOCK.
  - Owner deasserts req -> GAP.
- BLOCK:
  - Owner deasserting req ends the block -> GAP; blk_active clears.
  - A new blk_wstart inside BLOCK is forwarded and does not change state.
- GAP:
  - One dead cycle with gnt = 0, then IDLE.
  - Guarantees at least 1 idle bus cycle between owners, so back-to-back grants to different masters are 2 cycles apart minimum.
- Datapath:
  - All outputs are registered: the owner's strobe/addr/data at cycle n appear on the bus at n+1.
  - reg_waddr/reg_wdata hold their last value when no strobe is active.
  - Strobes are single-cycle pass-through: never stretched, never merged.
- Watchdog:
  - The hold counter resets on every new grant and increments each cycle in GRANT or BLOCK.
  - When it reaches HOLD_TIMEOUT-1: gnt clears next edge, any same-cycle strobe is suppressed, timeout_evt pulses, timeout_cnt increments (saturating at 16'hFFFF), state -> GAP.
  - A revoked master still holding req is re-arbitrated normally.
- Simultaneous events:
  - Owner drop of req together with a strobe in the same cycle: the strobe is forwarded, then GAP.
  - Timeout together with an owner req drop: treated as a timeout.
- last_owner updates when a grant issues.
- req, the strobes and m_* are synchronous to sysclk; no synchronisers.

Decomposition:
- Shared constants package (Constants.v style) holds:
  - state encodings WBA_IDLE/GRANT/BLOCK/GAP
  - arb_status bit-field positions
  - master index defines WBA_RT=0, WBA_FW=1, WBA_ETH=2
- One sub-module, wba_pick:
  - combinational priority/round-robin selector
  - inputs: req vector, pointer, PRIO_MODE
  - outputs: one-hot winner, encoded index, any-valid
- Main module holds the FSM, watchdog, status and output registers.

Test Plan:
- Single master: req[1] rises at cycle 0 -> gnt=3'b010 at cycle 1. Master 1 wen with addr 16'h0012, data 32'hDEADBEEF at cycle 2 -> reg_wen=1 with the same addr/data at cycle 3. req drop -> gnt=0, state GAP, then IDLE.
- Contention, PRIO_MODE=0: req=3'b110 -> gnt=3'b010. After release -> 1 GAP cycle -> gnt=3'b100. Master 2 wen while master 1 owns -> no reg_wen.
- Round-robin, PRIO_MODE=1, NUM_REQ=4: masters 1,2,3 continuously request with short transactions -> grant order 1,2,3,1. Asserting req[0] mid-sequence -> master 0 wins the next arbitration.
- Block write: owner issues blk_wstart, then 5 blk_wen (addrs 0x1000..0x1004) while req[2] pending -> 6 forwarded strobes in order, blk_active=1 throughout, gnt stays with the owner until its req drops.
- Timeout with HOLD_TIMEOUT=16: owner holds req with no strobes -> gnt clears exactly 16 cycles after grant, timeout_evt pulses once, arb_status[31:16]=1; a strobe in the revoke cycle is not forwarded.
- Reset during BLOCK: reset=1 for 1 cycle -> next edge all outputs 0, state IDLE, timeout_cnt 0; re-request grants in 1 cycle.
